btb_branch_predictor: RTL



---
 rtl/btb_branch_predictor_if.sv | 41 ++++
 rtl/btb_branch_predictor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/btb_branch_predictor_if.sv
// Fetch/EX-side bundle for the BTB next-PC predictor.
// Optional statistics outputs exist only when BTB_STATS_EN is defined.
interface btb_branch_predictor_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] pc_FE;
    logic [DBITS-1:0] pcpred_FE;
    logic             hit_FE;
    logic             predtaken_FE;
    logic             upd_valid_EX;
    logic [DBITS-1:0] upd_pc_EX;
    logic [DBITS-1:0] upd_target_EX;
    logic             upd_taken_EX;
    logic             upd_is_jmp_EX;
    logic             inval;
    logic             mispred_EX;
`ifdef BTB_STATS_EN
    logic [31:0]      stat_lookups;
    logic [31:0]      stat_hits;
    logic [31:0]      stat_updates;
    logic [31:0]      stat_mispred;
`endif

    modport master (
        output pc_FE, upd_valid_EX, upd_pc_EX, upd_target_EX, upd_taken_EX, upd_is_jmp_EX,
        output inval, mispred_EX,
        input  pcpred_FE, hit_FE, predtaken_FE
`ifdef BTB_STATS_EN
        , input stat_lookups, stat_hits, stat_updates, stat_mispred
`endif
    );

    modport slave (
        input  pc_FE, upd_valid_EX, upd_pc_EX, upd_target_EX, upd_taken_EX, upd_is_jmp_EX,
        input  inval, mispred_EX,
        output pcpred_FE, hit_FE, predtaken_FE
`ifdef BTB_STATS_EN
        , output stat_lookups, stat_hits, stat_updates, stat_mispred
`endif
    );
endinterface

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, EX-side training.
// Define BTB_STATS_EN to add lookup/hit/update/mispredict counters.
module btb_branch_predictor #(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned INSTSIZE     = 4,
    parameter int unsigned IMEMWORDBITS = 2,
    parameter int unsigned BTBIDXBITS   = 4,
    parameter int unsigned TAGBITS      = DBITS - BTBIDXBITS - IMEMWORDBITS
) (
    input logic                  clk,
    input logic                  reset,
    btb_branch_predictor_if.slave bus
);
    localparam int unsigned Entries = 1 << BTBIDXBITS;
    localparam int unsigned TagLsb  = BTBIDXBITS + IMEMWORDBITS;

    logic                  valid_q  [Entries];
    logic [1:0]            ctr_q    [Entries];
    logic [TAGBITS-1:0]    tag_q    [Entries];
    logic [DBITS-1:0]      target_q [Entries];

    // Lookup
    logic [BTBIDXBITS-1:0] l_idx;
    logic [TAGBITS-1:0]    l_tag;
    logic                  l_hit;
    logic                  l_taken;

    assign l_idx   = bus.pc_FE[TagLsb-1:IMEMWORDBITS];
    assign l_tag   = bus.pc_FE[DBITS-1:TagLsb];
    assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit && ctr_q[l_idx][1];

    assign bus.hit_FE       = l_hit;
    assign bus.predtaken_FE = l_taken;
    assign bus.pcpred_FE    = l_taken ? target_q[l_idx] : bus.pc_FE + DBITS'(INSTSIZE);

    // Update
    logic [BTBIDXBITS-1:0] u_idx;
    logic [TAGBITS-1:0]    u_tag;
    logic                  u_hit;
    logic                  upd_accept;
    logic                  entry_we;
    logic                  target_we;
    logic                  tag_we;
    logic [1:0]            ctr_d;

    assign u_idx      = bus.upd_pc_EX[TagLsb-1:IMEMWORDBITS];
    assign u_tag      = bus.upd_pc_EX[DBITS-1:TagLsb];
    assign u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_accept = bus.upd_valid_EX && !bus.inval;

    always_comb begin
        entry_we  = 1'b0;
        target_we = 1'b0;
        tag_we    = 1'b0;
        ctr_d     = ctr_q[u_idx];
        if (upd_accept) begin
            if (u_hit) begin
                entry_we = 1'b1;
                if (bus.upd_is_jmp_EX) begin
                    ctr_d     = 2'b11;
                    target_we = 1'b1;
                end else if (bus.upd_taken_EX) begin
                    ctr_d     = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'b01;
                    target_we = 1'b1;
                end else begin
                    ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'b01;
                end
            end else if (bus.upd_taken_EX) begin
                // Only taken outcomes allocate; not-taken misses leave the victim alone.
                entry_we  = 1'b1;
                target_we = 1'b1;
                tag_we    = 1'b1;
                ctr_d     = bus.upd_is_jmp_EX ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.inval) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (entry_we) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_d;
        end
    end

    // Tag and target are gated by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (target_we) target_q[u_idx] <= bus.upd_target_EX;
            if (tag_we)    tag_q[u_idx]    <= u_tag;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, updates_q, mispred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lookups_q <= 32'd0;
            hits_q    <= 32'd0;
            updates_q <= 32'd0;
            mispred_q <= 32'd0;
        end else begin
            lookups_q <= lookups_q + 32'd1;
            if (l_hit)          hits_q    <= hits_q + 32'd1;
            if (upd_accept)     updates_q <= updates_q + 32'd1;
            if (bus.mispred_EX) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign bus.stat_lookups = lookups_q;
    assign bus.stat_hits    = hits_q;
    assign bus.stat_updates = updates_q;
    assign bus.stat_mispred = mispred_q;
`else
    logic unused_mispred;
    assign unused_mispred = bus.mispred_EX;
`endif

    logic unused_offset;
    assign unused_offset = ^{bus.pc_FE[IMEMWORDBITS-1:0], bus.upd_pc_EX[IMEMWORDBITS-1:0]};
endmodule
